mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter: MUL_LAT, 5, busy cycles for MULT/MULTU.
REQ-002 Parameter: DIV_LAT, 10, busy cycles for DIV/DIVU.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: start  input  1  E-stage instruction is an MDU op; qualifies op/rs/rt.
REQ-006 Port: op  input  4  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO.
REQ-007 Port: rs  input  32  forwarded rs operand.
REQ-008 Port: rt  input  32  forwarded rt operand.
REQ-009 Port: flush  input  1  exception request; cancels this cycle's start.
REQ-010 Port: busy  output  1  high while a multiply or divide is in progress.
REQ-011 Port: mdout  output  32  combinational read: HI for MFHI, LO for MFLO, else 0.
REQ-012 Port: hi  output  32  current HI register.
REQ-013 Port: lo  output  32  current LO register.

Function
REQ-014 FSM states IDLE, MUL, DIV; a latency counter cnt is 4 bits wide.
REQ-015 An accepted start is start=1, flush=0 and state IDLE; all other starts are ignored without side effects.
REQ-016 In IDLE, accepted MULT/MULTU: latch the 64-bit signed/unsigned product, cnt<=MUL_LAT-1, go to MUL.
REQ-017 In IDLE, accepted DIV/DIVU: latch the quotient and remainder (signed truncates toward zero, remainder takes the dividend's sign), cnt<=DIV_LAT-1, go to DIV.
REQ-018 busy = (state != IDLE); busy rises the cycle after the accepted start and stays high for exactly MUL_LAT or DIV_LAT cycles.
REQ-019 In MUL/DIV: cnt decrements each cycle; on the cycle cnt==0, write the latched result to HI/LO and return to IDLE.
REQ-020 HI/LO are visible on hi/lo and mdout the first cycle busy is low.
REQ-021 Multiply result: HI=product[63:32], LO=product[31:0]; divide result: HI=remainder, LO=quotient.
REQ-022 A divide with rt==0 still spends DIV_LAT busy cycles and leaves HI/LO unchanged.
REQ-023 Signed DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-024 MTHI/MTLO accepted in IDLE write rs into HI/LO at that edge (1-cycle latency); busy stays low.
REQ-025 MFHI/MFLO have no state effect; mdout is valid in the same cycle.
REQ-026 flush never aborts an operation already in MUL/DIV; the result still commits.
REQ-027 If start with an MTHI/MTLO arrives in the same cycle as flush, the HI/LO write is suppressed.
REQ-028 A start seen while busy (stall logic violated) is ignored, and the in-flight result is unaffected.

Reset
REQ-029 When reset is low at a rising edge: state<=IDLE, cnt<=0, HI<=0, LO<=0, latched result<=0.
REQ-030 Reset overrides start and flush in the same cycle.
REQ-031 Reset during MUL/DIV discards the result; busy is 0 the following cycle.
REQ-032 All outputs read 0 immediately after reset.

Structure
REQ-033 The MDU_* op codes belong in the shared constants include used by the controller and the pipeline.
REQ-034 MUL_LAT and DIV_LAT stay local parameters of mdu_seq.
REQ-035 One combinational sub-module, mdu_arith, computes the 64-bit product and the quotient/remainder for op, rs and rt.
REQ-036 mdu_seq owns only the FSM, counter, latch and HI/LO registers.

Verification
REQ-037 MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-038 DIVU rs=17, rt=5 -> busy high for 10 cycles, then HI=2, LO=3; DIV rs=-7, rt=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-039 MTHI rs=0x1234 then MFHI the next cycle -> mdout=0x1234, busy never rises.
REQ-040 MULTU 0xFFFFFFFF*0xFFFFFFFF with flush=1 in the start cycle -> busy stays 0 and HI/LO are unchanged; the same op with flush=1 on its second busy cycle -> HI=0xFFFFFFFE, LO=1 after 5 cycles.
REQ-041 DIV rt=0 with HI=LO=0xA5 -> busy high for 10 cycles, then HI/LO still 0xA5.
REQ-042 Reset low on the 3rd cycle of a DIV -> busy=0 and HI=LO=0 on the next cycle, and no later result write.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared MDU constants: op codes used by the controller, pipeline and the
// multiply/divide unit, plus the sequencer state encoding.
package mdu_seq_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MFHI  = 4'd4;
  localparam logic [3:0] MDU_MFLO  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MTLO  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the MDU: 64-bit product and quotient/remainder,
// signed or unsigned depending on op.
module mdu_arith
  import mdu_seq_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  // Product and sign-magnitude division; magnitude form keeps -2^31 / -1 well defined
  always_comb begin
    sgn_s    = is_signed_op(op);
    a_neg_s  = sgn_s & rs[31];
    b_neg_s  = sgn_s & rt[31];
    a_ext_s  = sgn_s ? {{32{rs[31]}}, rs} : {32'd0, rs};
    b_ext_s  = sgn_s ? {{32{rt[31]}}, rt} : {32'd0, rt};
    prod     = a_ext_s * b_ext_s;
    a_mag_s  = a_neg_s ? (32'd0 - rs) : rs;
    b_mag_s  = b_neg_s ? (32'd0 - rt) : rt;
    div_zero = (rt == 32'd0);
    b_safe_s = div_zero ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / b_safe_s;
    r_mag_s  = a_mag_s % b_safe_s;
    quot     = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem      = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: latches the arithmetic result at start,
// holds busy for a fixed latency, then commits it to HI/LO.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] mdout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_r;
  mdu_state_e  state_s;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] res_hi_r;
  logic [31:0] res_lo_r;
  logic        res_wr_r;
  logic        accept_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        div_zero_s;

  mdu_arith u_arith (
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .prod     (prod_s),
    .quot     (quot_s),
    .rem      (rem_s),
    .div_zero (div_zero_s)
  );

  assign accept_s = start & ~flush & (state_r == ST_IDLE);
  assign is_mul_s = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div_s = (op == MDU_DIV) || (op == MDU_DIVU);

  // Next-state: leave IDLE only on an accepted mul/div, return when the count expires
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_s = ST_MUL;
        end else if (accept_s && is_div_s) begin
          state_s = ST_DIV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counter, result latch and HI/LO; a divide by zero latches a no-write flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r    <= 4'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      res_wr_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (accept_s && is_mul_s) begin
        res_hi_r <= prod_s[63:32];
        res_lo_r <= prod_s[31:0];
        res_wr_r <= 1'b1;
        cnt_r    <= 4'(MUL_LAT - 1);
      end else if (accept_s && is_div_s) begin
        res_hi_r <= rem_s;
        res_lo_r <= quot_s;
        res_wr_r <= ~div_zero_s;
        cnt_r    <= 4'(DIV_LAT - 1);
      end else if (accept_s && (op == MDU_MTHI)) begin
        hi_r <= rs;
      end else if (accept_s && (op == MDU_MTLO)) begin
        lo_r <= rs;
      end
    end else if (cnt_r == 4'd0) begin
      if (res_wr_r) begin
        hi_r <= res_hi_r;
        lo_r <= res_lo_r;
      end
    end else begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Move-from read path
  always_comb begin
    case (op)
      MDU_MFHI: mdout = hi_r;
      MDU_MFLO: mdout = lo_r;
      default:  mdout = 32'd0;
    endcase
  end

  assign busy = (state_r != ST_IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed ops push expected HI/LO/busy-length,
// a negedge monitor pops and compares whenever busy falls.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = MDU_MULT;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] mdout;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_len = 0;
  logic prev_busy = 1'b0;

  mdu_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .busy  (busy),
    .mdout (mdout),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endfunction

  function automatic void push(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.len = n;
    exp_q.push_back(e);
  endfunction

  // Monitor: a falling busy marks a completed (or reset-killed) operation
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_len++;
    end else begin
      if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy: busy fell after %0d cycles with nothing expected", busy_len);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_busy_len", 32'(busy_len), 32'(e.len));
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
        end
      end
      busy_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    flush = fl;
    step();
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!done) begin
        if (busy === 1'b0) done = 1'b1;
        else step();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after 30 cycles");
    end
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mdout", mdout, 32'd0);
    reset = 1'b1;
    step();

    // Multiply and divide results with their latencies
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    push(32'd2, 32'd3, 10);
    issue(MDU_DIVU, 32'd17, 32'd5, 1'b0);
    wait_idle();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    push(32'd0, 32'h8000_0000, 10);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    // Moves to and from HI/LO
    issue(MDU_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    start = 1'b1;
    op = MDU_MFHI;
    #1;
    check("mfhi_mdout", mdout, 32'h0000_1234);
    check("mthi_busy", 32'(busy), 32'd0);
    step();
    issue(MDU_MTLO, 32'h0000_5678, 32'd0, 1'b0);
    start = 1'b1;
    op = MDU_MFLO;
    #1;
    check("mflo_mdout", mdout, 32'h0000_5678);
    step();
    start = 1'b0;

    // Flush in the start cycle cancels; flush mid-operation does not
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step();
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, 32'h0000_1234);
    check("flush_lo", lo, 32'h0000_5678);
    issue(MDU_MTHI, 32'hBEEF, 32'd0, 1'b1);
    check("flush_mthi", hi, 32'h0000_1234);
    push(32'hFFFF_FFFE, 32'd1, 5);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle();

    // Starts while busy are ignored
    push(32'd2, 32'd3, 10);
    issue(MDU_DIVU, 32'd17, 32'd5, 1'b0);
    issue(MDU_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
    issue(MDU_MULT, 32'd7, 32'd7, 1'b0);
    wait_idle();
    check("busy_start_hi", hi, 32'd2);

    // Divide by zero leaves HI/LO untouched
    issue(MDU_MTHI, 32'h0000_00A5, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h0000_00A5, 32'd0, 1'b0);
    push(32'h0000_00A5, 32'h0000_00A5, 10);
    issue(MDU_DIV, 32'd1234, 32'd0, 1'b0);
    wait_idle();

    // Reset on the third busy cycle of a divide discards it
    push(32'd0, 32'd0, 3);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rstdiv_busy", 32'(busy), 32'd0);
    check("rstdiv_hi", hi, 32'd0);
    check("rstdiv_lo", lo, 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("rstdiv_late_hi", hi, 32'd0);
    check("rstdiv_late_lo", lo, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
